// File: rtl/trp_collect_if.sv
// Bus between trp_collect, its upstream transpose/reduction unit and its consumer.
// The master modport belongs to whatever drives the collector: it presents
// upstream words and sets the consumer's out_ready.
interface trp_collect_if #(
  parameter int WIDTH        = 10,
  parameter int NUMLANES     = 8,
  parameter int LOG2NUMLANES = 3
);
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_busy;
  logic [1:0]                mode;
  logic                      flush;
  logic                      rd;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUMLANES*WIDTH-1:0] out_data;
  logic [NUMLANES-1:0]       out_mask;
  logic [LOG2NUMLANES:0]     out_count;

  modport master (
    output in_valid, in_data, in_busy, mode, flush, out_ready,
    input  rd, out_valid, out_data, out_mask, out_count
  );

  modport slave (
    input  in_valid, in_data, in_busy, mode, flush, out_ready,
    output rd, out_valid, out_data, out_mask, out_count
  );
endinterface

// File: rtl/trp_collect.sv
// Collects upstream words into a NUMLANES-wide vector.
// Transpose mode (2'b11) fills every lane. Any other mode is reduction and
// emits one word per vector. A vector also closes early on flush, or when
// the upstream stream ends.
module trp_collect #(
  parameter int WIDTH        = 10,
  parameter int NUMLANES     = 8,
  parameter int LOG2NUMLANES = 3
) (
  input logic           clk,
  input logic           resetn,
  trp_collect_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [1:0]            MODE_TRANSPOSE = 2'b11;
  localparam logic [LOG2NUMLANES:0] FULL_COUNT     = (LOG2NUMLANES+1)'(NUMLANES);
  localparam logic [LOG2NUMLANES:0] ONE_COUNT      = (LOG2NUMLANES+1)'(1);

  state_t                    state_q, state_d;
  logic [NUMLANES*WIDTH-1:0] data_q, data_d;
  logic [NUMLANES-1:0]       mask_q, mask_d;
  logic [LOG2NUMLANES:0]     count_q, count_d;
  logic [1:0]                mode_q, mode_d;

  logic                      rd_w;
  logic                      accept;
  logic [LOG2NUMLANES:0]     target;
  logic [LOG2NUMLANES-1:0]   lane_idx;

  assign rd_w   = (state_q != HOLD);
  assign accept = rd_w & bus.in_valid;
  assign target = (mode_q == MODE_TRANSPOSE) ? FULL_COUNT : ONE_COUNT;
  // COLLECT is only entered with count below NUMLANES, so the index never wraps.
  assign lane_idx = count_q[LOG2NUMLANES-1:0];

  assign bus.rd        = rd_w;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_mask  = mask_q;
  assign bus.out_count = count_q;

  // Next-state and lane-write logic.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    count_d = count_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        // A flush with nothing collected is ignored: no empty vectors.
        if (accept) begin
          data_d              = '0;
          data_d[WIDTH-1:0]   = bus.in_data;
          mask_d              = '0;
          mask_d[0]           = 1'b1;
          count_d             = ONE_COUNT;
          mode_d              = bus.mode;
          state_d             = (bus.mode == MODE_TRANSPOSE) ? COLLECT : HOLD;
        end
      end
      COLLECT: begin
        // A same-cycle accept is captured before a flush or end-of-stream closes the vector.
        if (accept) begin
          data_d[lane_idx*WIDTH +: WIDTH] = bus.in_data;
          mask_d[lane_idx]                = 1'b1;
          count_d                         = count_q + 1'b1;
        end
        if ((count_d == target) || bus.flush || (!bus.in_valid && !bus.in_busy))
          state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          data_d  = '0;
          mask_d  = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: the lane storage is reset as well, because unwritten lanes must read 0 and reset discards partial data.
    if (!resetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      mode_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_trp_collect.sv
// Self-checking bench for trp_collect.
// A behavioural model turns each cycle's stimulus into expected vectors and
// queues them. A monitor on the falling edge compares whatever the DUT holds
// against the head of that queue.
module tb_trp_collect;
  localparam int WIDTH = 10;
  localparam int NL    = 8;
  localparam int LG    = 3;

  typedef struct {
    logic [NL*WIDTH-1:0] data;
    logic [NL-1:0]       mask;
    logic [LG:0]         count;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  trp_collect_if #(.WIDTH(WIDTH), .NUMLANES(NL), .LOG2NUMLANES(LG)) bus ();

  trp_collect #(.WIDTH(WIDTH), .NUMLANES(NL), .LOG2NUMLANES(LG)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  vec_t             exp_q[$];
  logic [WIDTH-1:0] words[$];
  bit               open_v = 0;
  bit               hold_v = 0;
  bit               is_tp  = 0;

  function automatic void close_vector();
    vec_t v;
    v.data  = '0;
    v.mask  = '0;
    v.count = (LG+1)'(words.size());
    foreach (words[i]) begin
      v.data[i*WIDTH +: WIDTH] = words[i];
      v.mask[i]                = 1'b1;
    end
    exp_q.push_back(v);
    words.delete();
    open_v = 0;
    hold_v = 1;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      words.delete();
      open_v = 0;
      hold_v = 0;
    end else if (hold_v) begin
      if (bus.out_ready) hold_v = 0;
    end else if (!open_v) begin
      if (bus.in_valid) begin
        words.push_back(bus.in_data);
        is_tp  = (bus.mode == 2'b11);
        open_v = 1;
        if (!is_tp) close_vector();
      end
    end else begin
      if (bus.in_valid) words.push_back(bus.in_data);
      if ((words.size() == NL) || bus.flush || (!bus.in_valid && !bus.in_busy))
        close_vector();
    end
  end

  // ---------------- monitor ----------------
  bit   mon_en   = 0;
  bit   have_cur = 0;
  vec_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 128'(bus.out_valid), 128'(hold_v));
      check("rd", 128'(bus.rd), 128'(!hold_v));
      if (bus.out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            check("unexpected_vector", 128'(1), 128'(0));
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1;
          end
        end
        if (have_cur) begin
          check("out_data", 128'(bus.out_data), 128'(cur.data));
          check("out_mask", 128'(bus.out_mask), 128'(cur.mask));
          check("out_count", 128'(bus.out_count), 128'(cur.count));
        end
        if (bus.out_ready || !resetn) have_cur = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic busy,
                       input logic [1:0] m, input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_busy   = busy;
    bus.mode      = m;
    bus.flush     = fl;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 2'b00, 1'b0, rdy);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_mask"},  128'(bus.out_mask),  128'(0));
    check({tag, "_count"}, 128'(bus.out_count), 128'(0));
    check({tag, "_data"},  128'(bus.out_data),  128'(0));
    check({tag, "_rd"},    128'(bus.rd),        128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_busy   = 1'b1;
    bus.mode      = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;
    resetn = 1'b1;
    check_zero_outputs("reset");

    // Full transpose, then 5 cycles of backpressure with words offered, then release.
    for (int i = 0; i < NL; i++) drive(1'b1, WIDTH'(i + 1), 1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'(10'h3A0 + i), 1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 2'b11, 1'b0, 1'b1);
    check_zero_outputs("after_hs");

    // Reduction: a single word.
    drive(1'b1, 10'h155, 1'b1, 2'b00, 1'b0, 1'b0);
    idle_cycles(1, 1'b0);
    idle_cycles(2, 1'b1);

    // Partial vector closed by end of stream.
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(10'h20 + i), 1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 2'b11, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // Partial vector closed by a flush that coincides with an accept.
    for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(10'h40 + i), 1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b1, 10'h043, 1'b1, 2'b11, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // Reset after 4 transpose accepts, then a clean full vector.
    for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'(10'h60 + i), 1'b1, 2'b11, 1'b0, 1'b0);
    resetn = 1'b0;
    drive(1'b0, '0, 1'b1, 2'b11, 1'b0, 1'b0);
    resetn = 1'b1;
    check_zero_outputs("mid_reset");
    for (int i = 0; i < NL; i++) drive(1'b1, WIDTH'(10'h80 + i), 1'b1, 2'b11, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // Mode changes to 01 after 2 accepts; the target stays at NL.
    for (int i = 0; i < NL; i++)
      drive(1'b1, WIDTH'(10'h100 + i), 1'b1, (i < 2) ? 2'b11 : 2'b01, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // Random traffic, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
    end
    resetn = 1'b1;

    // Drain: close any open vector and hand it off.
    drive(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
    idle_cycles(4, 1'b1);
    @(negedge clk);
    check("exp_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trp_collect.md
TRP_COLLECT -- requirements
Module: trp_collect

Interface
REQ-001 SHALL have parameter WIDTH, default 10, element width in bits.
REQ-002 SHALL have parameter NUMLANES, default 8, lanes per assembled vector (power of two, >=2).
REQ-003 SHALL have parameter LOG2NUMLANES, default 3, log2(NUMLANES).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream transpose/reduction unit presenting a word.
REQ-007 in_data  input  WIDTH  word from the upstream unit.
REQ-008 in_busy  input  1  upstream unit busy; low with in_valid low means the stream has ended.
REQ-009 mode  input  2  operation mode; 2'b11 = transpose, otherwise reduction.
REQ-010 flush  input  1  force close of a partially collected vector.
REQ-011 rd  output  1  read/pop strobe to the upstream unit; high = word accepted this cycle if in_valid.
REQ-012 out_valid  output  1  assembled vector available.
REQ-013 out_ready  input  1  consumer accepts vector.
REQ-014 out_data  output  NUMLANES*WIDTH  assembled vector, lane i at bits [i*WIDTH +: WIDTH].
REQ-015 out_mask  output  NUMLANES  bit i set = lane i written.
REQ-016 out_count  output  LOG2NUMLANES+1  number of lanes written.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, HOLD.
REQ-018 Accept = rd & in_valid; a word SHALL be captured only on accept.
REQ-019 rd SHALL be 1 in IDLE and COLLECT, 0 in HOLD (combinational from state).
REQ-020 Target count SHALL be NUMLANES when the latched mode is 2'b11, else 1.
REQ-021 mode SHALL be latched on the first accept in IDLE; mode changes in COLLECT/HOLD SHALL be ignored.
REQ-022 IDLE: on accept write lane 0, mask bit 0, count=1; next state HOLD if target==1, else COLLECT.
REQ-023 IDLE without accept SHALL stay IDLE; flush in IDLE SHALL be ignored (no empty vectors emitted).
REQ-024 COLLECT: on accept write lane[count], set mask[count], count+1; go HOLD when new count == target.
REQ-025 COLLECT: flush=1 SHALL go HOLD next cycle; a same-cycle accept SHALL be captured first.
REQ-026 COLLECT: in_valid=0 and in_busy=0 SHALL go HOLD next cycle with the partial vector.
REQ-027 HOLD: out_valid=1; out_data/out_mask/out_count SHALL be stable until handshake.
REQ-028 HOLD: out_ready=1 SHALL return to IDLE and clear lanes, mask and count to 0 in the same edge.
REQ-029 Lane index SHALL never wrap; count saturates at NUMLANES since HOLD blocks further accepts.
REQ-030 Unwritten lanes SHALL read 0 on out_data.
REQ-031 Latency: last accept at edge N -> out_valid high after edge N; handshake at edge M -> rd high after edge M.
REQ-032 out_valid SHALL be 0 in IDLE and COLLECT.

Reset
REQ-033 On resetn=0 at a clock edge: state IDLE, lanes, mask, count, latched mode all 0.
REQ-034 After reset: out_valid=0, out_mask=0, out_count=0, out_data=0, rd=1.
REQ-035 Reset in any state, including mid-COLLECT or HOLD, SHALL discard partial data with no output.

Verification
REQ-036 Transpose: mode=11, 8 consecutive accepts 0x001..0x008 -> out_valid next cycle, lane i = i+1, mask=0xFF, count=8, rd=0.
REQ-037 Reduction: mode=00, one accept 0x155 -> HOLD next cycle, lane0=0x155, mask=0x01, count=1, other lanes 0.
REQ-038 Partial: mode=11, 3 accepts then in_valid=0,in_busy=0 -> HOLD, mask=0x07, count=3; flush-with-accept variant gives mask=0x0F, count=4.
REQ-039 Backpressure: HOLD with out_ready=0 for 5 cycles -> outputs stable, rd=0, in_valid words not captured; out_ready=1 -> IDLE, outputs zero.
REQ-040 Reset mid-operation: resetn=0 after 4 transpose accepts -> next cycle IDLE, mask=0, count=0; a following 8-word transpose gives correct full vector.
REQ-041 Mode change mid-COLLECT: mode 11 -> 01 after 2 accepts -> target stays 8, full vector emitted after 8 accepts.
